// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Inter-stage pipeline register for the ARM-subset core. Moves an opaque
//   control bundle and data bundle from one stage to the next under
//   valid/ready flow control. It supports a synchronous flush, bubble masking
//   of the control bits, and a saturating back-pressure counter for
//   performance debug.
//   With SKID=1 a second (skid) register sits behind the main register. This
//   lets in_ready come straight from a flop, so a stall does not ripple
//   combinationally up the pipe.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous kill of held entries and of this cycle's input
//   in_valid   upstream has an entry
//   in_ready   stage accepts an entry this cycle
//   in_ctrl    upstream control bundle (CTRL_W)
//   in_data    upstream data bundle (DATA_W)
//   out_valid  downstream entry present
//   out_ready  downstream consumes this cycle
//   out_ctrl   control bundle, zero whenever out_valid=0
//   out_data   data bundle (unmasked)
//   occupancy  entries held, 0..2 (0..1 when SKID=0)
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
//
// SKID=1 occupancy FSM
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0
//   ST_ONE   | main register holds the oldest entry, skid empty
//   ST_FULL  | main holds oldest, skid holds next; in_ready=0

module pipe_stage_reg #(
  parameter int CTRL_W     = 9,
  parameter int DATA_W     = 144,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  logic              push;
  logic              pop;
  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;

  assign push      = in_valid & in_ready;
  assign pop       = main_valid & out_ready;

  assign out_valid = main_valid;
  // A bubble must never present write or memory enables downstream.
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data  = main_data;

  // Stall counter survives flush on purpose: it reflects every lost cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      state_t            state_q;
      state_t            state_nxt;
      logic              in_ready_q;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      // State register. in_ready is registered from the next state, so it
      // equals "skid register empty" without any combinational path.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q    <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_nxt;
          in_ready_q <= (state_nxt != ST_FULL);
        end
      end

      // Next-state logic. Flush wins over push and pop.
      always_comb begin
        state_nxt = state_q;
        if (flush) begin
          state_nxt = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
              if (push && !pop)      state_nxt = ST_FULL;
              else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
          endcase
        end
      end

      // Output logic
      always_comb begin
        main_valid = (state_q != ST_EMPTY);
        in_ready   = in_ready_q;
        occupancy  = state_q;
      end

      // Datapath: main always holds the oldest entry. Skid data moves into
      // main when the oldest is consumed while full.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_ctrl <= '0;
          main_data <= '0;
          skid_ctrl <= '0;
          skid_data <= '0;
        end else if (flush) begin
          main_ctrl <= '0;
          skid_ctrl <= '0;
          if (CLEAR_DATA != 0) begin
            main_data <= '0;
            skid_data <= '0;
          end
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (push) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
              end
            end
            ST_ONE: begin
              if (push && pop) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
              end else if (push) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
              end
            end
            ST_FULL: begin
              if (pop) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
              end
            end
            default: ;
          endcase
        end
      end
    end else begin : g_noskid
      // Single register. Ready is combinational from downstream.
      always_comb begin
        in_ready  = out_ready | ~main_valid;
        occupancy = {1'b0, main_valid};
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_valid <= 1'b0;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (push) begin
          main_valid <= 1'b1;
        end else if (pop) begin
          main_valid <= 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_ctrl <= '0;
          main_data <= '0;
        end else if (flush) begin
          main_ctrl <= '0;
          if (CLEAR_DATA != 0) main_data <= '0;
        end else if (push) begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. Three instances share one stimulus stream:
//   0: SKID=1 CLEAR_DATA=1   1: SKID=1 CLEAR_DATA=0   2: SKID=0 CLEAR_DATA=1
// Each instance is compared against a plain FIFO reference model whose
// capacity is 2 (skid) or 1 (no skid).
module tb_pipe_stage_reg;
  localparam int CW = 9;
  localparam int DW = 144;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic [2:0]           in_rdy;
  logic [2:0]           o_valid;
  logic [2:0][CW-1:0]   o_ctrl;
  logic [2:0][DW-1:0]   o_data;
  logic [2:0][1:0]      occ;
  logic [2:0][15:0]     stall;

  int checks = 0;
  int failures = 0;

  logic [CW-1:0] m_ctrl [3][2];
  logic [DW-1:0] m_data [3][2];
  int            m_cnt  [3];
  int            m_stall[3];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1)) dut_skid_clr (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_ctrl(o_ctrl[0]), .out_data(o_data[0]), .occupancy(occ[0]), .stall_cnt(stall[0]));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(0)) dut_skid_hold (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_ctrl(o_ctrl[1]), .out_data(o_data[1]), .occupancy(occ[1]), .stall_cnt(stall[1]));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(1)) dut_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(o_valid[2]), .out_ready(out_ready),
    .out_ctrl(o_ctrl[2]), .out_data(o_data[2]), .occupancy(occ[2]), .stall_cnt(stall[2]));

  task automatic chk(input string tag, input int i, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {16'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]   = 0;
      m_stall[i] = 0;
    end
  endtask

  task automatic chk_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", i, DW'(o_valid[i]), '0);
      chk("rst_out_ctrl",  i, DW'(o_ctrl[i]),  '0);
      chk("rst_out_data",  i, o_data[i],       '0);
      chk("rst_occupancy", i, DW'(occ[i]),     '0);
      chk("rst_stall_cnt", i, DW'(stall[i]),   '0);
      chk("rst_in_ready",  i, DW'(in_rdy[i]),  DW'(1));
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      logic ev;
      ev = (m_cnt[i] > 0);
      chk("out_valid", i, DW'(o_valid[i]), DW'(ev));
      chk("out_ctrl",  i, DW'(o_ctrl[i]),  ev ? DW'(m_ctrl[i][0]) : '0);
      if (ev) chk("out_data", i, o_data[i], m_data[i][0]);
      chk("occupancy", i, DW'(occ[i]),   DW'(m_cnt[i]));
      chk("stall_cnt", i, DW'(stall[i]), DW'(m_stall[i]));
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance the model across the
  // edge, then check the registered outputs.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
    logic psh [3];
    logic pp  [3];
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #2;
    for (int i = 0; i < 3; i++) begin
      logic er;
      er = (i == 2) ? (ordy || m_cnt[i] == 0) : (m_cnt[i] < 2);
      chk("in_ready", i, DW'(in_rdy[i]), DW'(er));
      psh[i] = v && er;
      pp[i]  = (m_cnt[i] > 0) && ordy;
      if (m_cnt[i] > 0 && !ordy && m_stall[i] < 65535) m_stall[i]++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (fl) begin
        m_cnt[i] = 0;
      end else begin
        if (pp[i]) begin
          m_ctrl[i][0] = m_ctrl[i][1];
          m_data[i][0] = m_data[i][1];
          m_cnt[i]--;
        end
        if (psh[i]) begin
          m_ctrl[i][m_cnt[i]] = c;
          m_data[i][m_cnt[i]] = d;
          m_cnt[i]++;
        end
      end
    end
    check_outputs();
  endtask

  initial begin
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;

    // asynchronous reset with no clock edge
    #1 rst = 1'b0;
    #2;
    clear_model();
    chk_reset();
    @(posedge clk);
    #1 rst = 1'b1;

    // streaming
    step(1'b1, 9'h1A5, rand_data(), 1'b1, 1'b0);
    step(1'b1, 9'h0F3, rand_data(), 1'b1, 1'b0);
    step(1'b0, 9'h000, '0, 1'b1, 1'b0);

    // back-pressure: A, B, C offered while downstream stalls, then release
    step(1'b1, 9'h0A1, DW'(32'h0000_0010), 1'b0, 1'b0);
    step(1'b1, 9'h0B2, DW'(32'h0000_0014), 1'b0, 1'b0);
    step(1'b1, 9'h0C3, DW'(32'h0000_0018), 1'b0, 1'b0);
    step(1'b0, 9'h000, '0, 1'b0, 1'b0);
    step(1'b0, 9'h000, '0, 1'b1, 1'b0);
    step(1'b0, 9'h000, '0, 1'b1, 1'b0);
    step(1'b0, 9'h000, '0, 1'b1, 1'b0);

    // flush while full, with a valid input in the flush cycle
    d1 = rand_data();
    d2 = rand_data();
    step(1'b1, 9'h011, d1, 1'b0, 1'b0);
    step(1'b1, 9'h022, d2, 1'b0, 1'b0);
    step(1'b1, 9'h033, rand_data(), 1'b0, 1'b1);
    chk("flush_data_clear", 0, o_data[0], '0);
    chk("flush_data_hold",  1, o_data[1], d1);
    chk("flush_data_clear", 2, o_data[2], '0);
    step(1'b0, 9'h000, '0, 1'b1, 1'b0);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 3) != 0, 9'($urandom), rand_data(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    step(1'b0, 9'h000, '0, 1'b1, 1'b0);
    step(1'b0, 9'h000, '0, 1'b1, 1'b0);

    // continuous input, out_ready pattern 1,0,1
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 9'(k + 1), DW'(k + 100), (k % 3) != 1, 1'b0);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 9'h000, '0, 1'b1, 1'b0);

    // async reset between edges while full
    step(1'b1, 9'h155, rand_data(), 1'b0, 1'b0);
    step(1'b1, 9'h0AA, rand_data(), 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    clear_model();
    chk_reset();
    #1 rst = 1'b1;
    step(1'b1, 9'h1FF, rand_data(), 1'b0, 1'b0);

    // stall counter saturation
    in_valid = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("stall_near_sat", i, DW'(stall[i]), DW'(16'hFFFE));
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("stall_sat", i, DW'(stall[i]), DW'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers of the ARM-subset core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque control bundle and data bundle between stages with valid/ready flow control, synchronous flush and an optional 2-entry skid buffer, so stalls can propagate without combinational ready chains.
- Adds bubble masking of control bits and a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 9: width of the control bundle (wb_en, mem_read_en, mem_write_en, B, S, exe_cmd, ...); masked to zero on bubbles.
- DATA_W, 144: width of the data bundle (PC, val_Rn, val_Rm, shift_operand, dest, status, imm, signed_imm_24, ...).
- SKID, 1: 0 = single register with combinational ready; 1 = main register plus skid register with registered ready.
- CLEAR_DATA, 1: 1 = flush also zeroes data registers; 0 = data registers hold their value on flush.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all held entries and of this cycle's input
- in_valid  input  1  upstream has an entry
- in_ready  output  1  stage accepts an entry this cycle
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- out_valid  output  1  downstream entry present
- out_ready  input  1  downstream consumes this cycle
- out_ctrl  output  CTRL_W  control bundle, forced 0 when out_valid=0
- out_data  output  DATA_W  data bundle
- occupancy  output  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  output  16  saturating count of back-pressure cycles

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, skid entry invalid, all ctrl/data registers 0, occupancy=0, stall_cnt=0; in_ready=1 when SKID=1.
- Transfer rules: push = in_valid & in_ready; pop = out_valid & out_ready. Latency is 1 cycle: an entry pushed at edge N appears on out_* after edge N.
- SKID=0: in_ready = out_ready | ~out_valid (combinational). On push, the main register loads in_*. On pop without push, out_valid becomes 0.
- SKID=1: in_ready = ~skid_valid, driven directly from a flop.
  - EMPTY (occ 0): push -> ONE.
  - ONE (occ 1): push & pop -> ONE (main loads input); push & ~pop -> FULL (input goes to skid); pop & ~push -> EMPTY.
  - FULL (occ 2): in_ready=0; pop -> ONE (skid moves to main, skid invalidated); no pop -> FULL (hold).
  - Order is preserved; main always holds the oldest entry.
- Flush has priority over push and pop in the same cycle:
  - At the next edge: out_valid=0, skid invalid, occupancy=0, ctrl registers=0; data registers=0 if CLEAR_DATA=1, otherwise unchanged.
  - The input presented in the flush cycle is dropped even if in_ready=1.
  - A pop in the flush cycle is still seen by downstream, because outputs are valid during that cycle.
- Bubble masking: out_ctrl = ctrl_reg AND out_valid, so a bubble never asserts write or memory enables.
- out_data is unmasked; it is don't-care when out_valid=0, apart from the CLEAR_DATA guarantee above.
- stall_cnt increments on every cycle with out_valid=1 & out_ready=0. It saturates at 16'hFFFF, is unaffected by flush and is cleared only by reset.
- Reset asserted mid-transfer: all state is cleared immediately (asynchronous); no partial entry survives. After rst releases, the first push is accepted on the first clk edge.
- in_valid is not required to stay high while in_ready=0. The block never accepts data when in_ready=0.

Test Plan:
- Streaming (SKID=1, out_ready=1): push ctrl 9'h1A5 then 9'h0F3 on consecutive cycles -> out_ctrl shows 1A5 then 0F3, one cycle later each; occupancy stays 1; stall_cnt=0.
- Back-pressure (SKID=1): out_ready=0, push A (data 32'h0000_0010), then B (32'h0000_0014), then C -> in_ready drops after B; C not accepted; occupancy=2. Release out_ready -> A, then B delivered in order; stall_cnt equals the number of held cycles.
- Flush while FULL (CLEAR_DATA=1), with in_valid=1 during flush -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0; the flushing-cycle input is absent downstream.
- CLEAR_DATA=0 flush -> out_data retains the old value; out_ctrl=0; out_valid=0.
- SKID=0, out_ready toggling 1,0,1 with continuous in_valid -> in_ready mirrors out_ready whenever out_valid=1; no loss or duplication over 20 entries.
- Asynchronous reset pulse between edges while occupancy=2 -> outputs clear without a clock edge; stall_cnt=0. Hold out_ready=0 for 70000 cycles -> stall_cnt stops at 16'hFFFF.
